// File: rtl/stim_lfsr_gen.sv
// Burst stimulus generator: on an accepted start, emits burst_len pseudo-random
// bit pairs on in1/in2 from a 16-bit Fibonacci LFSR, then pulses done for one cycle.
module stim_lfsr_gen #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             in1,
    output logic             in2,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      lfsr_q
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [CNT_W-1:0] len;
    logic             last_pair;

    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign last_pair = (count == len - CNT_W'(1));
    assign lfsr_q    = lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (burst_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_pair) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        in1   = 1'b0;
        in2   = 1'b0;
        case (state)
            RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
                in1   = lfsr[0];
                in2   = lfsr[1];
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    // A zero-length start goes straight to DONE and leaves lfsr/count untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr  <= SEED_EFF;
            len   <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && start && burst_len != '0) begin
                lfsr  <= SEED_EFF;
                len   <= burst_len;
                count <= '0;
            end else if (state == RUN) begin
                lfsr  <= lfsr_next;
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stim_lfsr_gen.sv
// Directed self-checking bench for stim_lfsr_gen: single bursts, zero length,
// back-to-back bursts, mid-burst input changes, async reset and a full-length burst.
module tb_stim_lfsr_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic       in1;
    logic       in2;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] count;
    logic [15:0] lfsr_q;

    int checks;
    int failures;

    stim_lfsr_gen #(
        .SEED  (16'hACE1),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .in1       (in1),
        .in2       (in2),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .lfsr_q    (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] len);
        start     = s;
        burst_len = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected of a non-RUN, non-DONE state.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_in"}, 32'({in1, in2}), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_lfsr [3];
        logic [1:0]  exp_pair [3];
        logic [15:0] model;
        int          valid_seen;
        int          done_seen;

        checks   = 0;
        failures = 0;
        exp_lfsr = '{16'hACE1, 16'h5670, 16'hAB38};
        exp_pair = '{2'b10, 2'b00, 2'b00};

        rst = 1'b1;
        applyStimulus(1'b0, 8'd0);
        tick();
        checkQuiet("reset");
        checkOutput("reset_lfsr", 32'(lfsr_q), 32'hACE1);
        checkOutput("reset_count", 32'(count), 32'd0);
        rst = 1'b0;
        tick();
        checkQuiet("idle");

        // Three-pair burst with hand-computed data.
        applyStimulus(1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("b3_valid%0d", i), 32'(valid), 32'd1);
            checkOutput($sformatf("b3_busy%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("b3_done%0d", i), 32'(done), 32'd0);
            checkOutput($sformatf("b3_lfsr%0d", i), 32'(lfsr_q), 32'(exp_lfsr[i]));
            checkOutput($sformatf("b3_pair%0d", i), 32'({in1, in2}), 32'(exp_pair[i]));
            checkOutput($sformatf("b3_count%0d", i), 32'(count), 32'(i));
            tick();
        end
        checkOutput("b3_done", 32'(done), 32'd1);
        checkOutput("b3_done_busy", 32'(busy), 32'd1);
        checkOutput("b3_done_valid", 32'(valid), 32'd0);
        checkOutput("b3_final_count", 32'(count), 32'd3);
        checkOutput("b3_final_lfsr", 32'(lfsr_q), 32'h559C);
        tick();
        checkQuiet("b3_after");
        checkOutput("b3_hold_count", 32'(count), 32'd3);

        // Zero-length request: DONE only, state registers untouched.
        applyStimulus(1'b1, 8'd0);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("z_done", 32'(done), 32'd1);
        checkOutput("z_busy", 32'(busy), 32'd1);
        checkOutput("z_valid", 32'(valid), 32'd0);
        checkOutput("z_count", 32'(count), 32'd3);
        checkOutput("z_lfsr", 32'(lfsr_q), 32'h559C);
        tick();
        checkQuiet("z_after");

        // start held high: RUN, RUN, DONE, IDLE, repeating from ACE1.
        applyStimulus(1'b1, 8'd2);
        for (int b = 0; b < 2; b++) begin
            tick();
            checkOutput($sformatf("bb%0d_v0", b), 32'(valid), 32'd1);
            checkOutput($sformatf("bb%0d_l0", b), 32'(lfsr_q), 32'hACE1);
            tick();
            checkOutput($sformatf("bb%0d_v1", b), 32'(valid), 32'd1);
            checkOutput($sformatf("bb%0d_l1", b), 32'(lfsr_q), 32'h5670);
            tick();
            checkOutput($sformatf("bb%0d_done", b), 32'(done), 32'd1);
            checkOutput($sformatf("bb%0d_cnt", b), 32'(count), 32'd2);
            tick();
            checkQuiet($sformatf("bb%0d_idle", b));
        end
        applyStimulus(1'b0, 8'd0);
        tick();
        checkQuiet("bb_end");

        // start re-pulsed and burst_len changed mid-burst must be ignored.
        applyStimulus(1'b1, 8'd5);
        tick();
        valid_seen = 32'(valid);
        done_seen  = 32'(done);
        applyStimulus(1'b1, 8'd1);
        tick();
        valid_seen += 32'(valid);
        done_seen  += 32'(done);
        applyStimulus(1'b0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            valid_seen += 32'(valid);
            done_seen  += 32'(done);
        end
        checkOutput("chg_valid_cycles", 32'(valid_seen), 32'd5);
        checkOutput("chg_done_pulses", 32'(done_seen), 32'd1);
        checkOutput("chg_count", 32'(count), 32'd5);

        // Async reset in the third RUN cycle aborts without a done pulse.
        applyStimulus(1'b1, 8'd5);
        tick();
        applyStimulus(1'b0, 8'd0);
        tick();
        tick();
        checkOutput("rst_pre_valid", 32'(valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkQuiet("rst_mid");
        checkOutput("rst_mid_lfsr", 32'(lfsr_q), 32'hACE1);
        checkOutput("rst_mid_count", 32'(count), 32'd0);
        tick();
        checkOutput("rst_hold_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        checkQuiet("rst_post");
        applyStimulus(1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("rst_reseed_lfsr", 32'(lfsr_q), 32'hACE1);
        checkOutput("rst_reseed_valid", 32'(valid), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("rst_burst_done", 32'(done), 32'd1);
        tick();

        // Full-length burst against the reference LFSR model.
        applyStimulus(1'b1, 8'd255);
        tick();
        applyStimulus(1'b0, 8'd0);
        model = 16'hACE1;
        for (int i = 0; i < 255; i++) begin
            checkOutput($sformatf("max_valid%0d", i), 32'(valid), 32'd1);
            checkOutput($sformatf("max_lfsr%0d", i), 32'(lfsr_q), 32'(model));
            checkOutput($sformatf("max_nonzero%0d", i), 32'(lfsr_q == 16'h0), 32'd0);
            checkOutput($sformatf("max_count%0d", i), 32'(count), 32'(i));
            checkOutput($sformatf("max_pair%0d", i), 32'({in1, in2}),
                        32'({model[0], model[1]}));
            model = lfsr_step(model);
            tick();
        end
        checkOutput("max_done", 32'(done), 32'd1);
        checkOutput("max_count", 32'(count), 32'd255);
        tick();
        checkQuiet("max_after");
        checkOutput("max_hold_count", 32'(count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
